// File: rtl/ram_sp_arb_128x64.sv
// Round-robin arbiter/sequencer in front of a 128x64 bit-enable single-port RAM; `RAM_ARB_INIT_EN adds a post-reset zero-fill sweep.
// Latency: ack in the same cycle as req; rvld and read data one cycle after the read ack.
// Backpressure: a master without ack holds its request stable; nothing is queued, one access per cycle total.
module ram_sp_arb_128x64 (
    input  logic        clk,
    input  logic        rstn,
    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [6:0]  m0_adr_i,
    input  logic [63:0] m0_msk_i,
    input  logic [63:0] m0_dat_i,
    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [6:0]  m1_adr_i,
    input  logic [63:0] m1_msk_i,
    input  logic [63:0] m1_dat_i,
    output logic        m0_ack_o,
    output logic        m1_ack_o,
    output logic        m0_rvld_o,
    output logic        m1_rvld_o,
    output logic [63:0] rd_dat_o,
    output logic        init_done_o,
    output logic [6:0]  ram_adr_o,
    output logic [63:0] ram_wr_ena_o,
    output logic [63:0] ram_wr_dat_o,
    output logic        ram_rd_ena_o,
    input  logic [63:0] ram_rd_dat_i
);

    logic serving;
    logic prio;     // 0: master 0 wins a tie, 1: master 1 wins
    logic gnt0, gnt1;
    logic rvld0, rvld1;

`ifdef RAM_ARB_INIT_EN
    typedef enum logic {INIT, SERVE} state_t;
    state_t     state, state_nxt;
    logic [6:0] sweep_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= INIT;
            sweep_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == INIT)
                sweep_cnt <= sweep_cnt + 7'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == INIT && sweep_cnt == 7'd127)
            state_nxt = SERVE;
    end

    assign serving = (state == SERVE);
`else
    assign serving = 1'b1;
`endif

    // RAM port and grants are gated by rstn so the interface idles the moment reset asserts.
    always_comb begin
        gnt0         = 1'b0;
        gnt1         = 1'b0;
        ram_adr_o    = '0;
        ram_wr_ena_o = '0;
        ram_wr_dat_o = '0;
        ram_rd_ena_o = 1'b0;
        if (rstn) begin
            if (!serving) begin
`ifdef RAM_ARB_INIT_EN
                ram_adr_o    = sweep_cnt;
                ram_wr_ena_o = '1;
`endif
            end else begin
                gnt0 = m0_req_i & (~m1_req_i | ~prio);
                gnt1 = m1_req_i & (~m0_req_i | prio);
                if (gnt0) begin
                    ram_adr_o = m0_adr_i;
                    if (m0_we_i) begin
                        ram_wr_ena_o = m0_msk_i;
                        ram_wr_dat_o = m0_dat_i;
                    end else begin
                        ram_rd_ena_o = 1'b1;
                    end
                end else if (gnt1) begin
                    ram_adr_o = m1_adr_i;
                    if (m1_we_i) begin
                        ram_wr_ena_o = m1_msk_i;
                        ram_wr_dat_o = m1_dat_i;
                    end else begin
                        ram_rd_ena_o = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prio  <= 1'b0;
            rvld0 <= 1'b0;
            rvld1 <= 1'b0;
        end else begin
            if (gnt0)
                prio <= 1'b1;
            else if (gnt1)
                prio <= 1'b0;
            rvld0 <= gnt0 & ~m0_we_i;
            rvld1 <= gnt1 & ~m1_we_i;
        end
    end

    assign m0_ack_o    = gnt0;
    assign m1_ack_o    = gnt1;
    assign m0_rvld_o   = rvld0;
    assign m1_rvld_o   = rvld1;
    assign rd_dat_o    = (rvld0 | rvld1) ? ram_rd_dat_i : '0;
    assign init_done_o = serving;

endmodule
